// File: rtl/dpu_cmd_responder.sv
// DPU host command responder.
// Decodes byte-level host commands into region writes, fmap reads with a
// registered response, layer/scale register updates and conv-engine runs.
// Owns the busy/done/current_layer status and the ping-pong buffer selector.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | ready for a command; set-layer/scale/illegal complete here
// WR      | write strobe on the memory port, then back to IDLE
// RD_WAIT | read issued, waiting out the memory read latency
// RSP     | read response strobe on the response port
// RUN     | engine started, waiting for run_done
// FIN     | done pulse, ping-pong toggled, back to IDLE
module dpu_cmd_responder #(
    parameter int MAX_CH   = 256,
    parameter int MAX_FMAP = 65536,
    parameter int MAX_WBUF = 147456,
    parameter int RD_LAT   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_type,
    input  logic [23:0] cmd_addr,
    input  logic [7:0]  cmd_data,
    output logic        rsp_valid,
    output logic [7:0]  rsp_data,
    output logic        mem_we,
    output logic        mem_re,
    output logic [1:0]  mem_sel,
    output logic [23:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic        run_start,
    input  logic        run_done,
    output logic        busy,
    output logic        done,
    output logic [4:0]  current_layer,
    output logic [15:0] scale,
    output logic        ping_pong,
    output logic        bad_cmd
);

    localparam logic [31:0] L_WBUF_END  = 32'(MAX_WBUF);
    localparam logic [31:0] L_FMAP_BASE = 32'(MAX_WBUF + MAX_CH * 4);
    localparam logic [31:0] L_FMAP_END  = 32'(MAX_WBUF + MAX_CH * 4 + MAX_FMAP);
    localparam logic [31:0] L_FMAP_SIZE = 32'(MAX_FMAP);
    localparam logic [23:0] L_BIAS_OFF  = 24'(MAX_WBUF);
    localparam logic [23:0] L_FMAP_OFF  = 24'(MAX_WBUF + MAX_CH * 4);
    localparam logic [2:0]  L_RD_LAT    = 3'(RD_LAT);

    localparam logic [2:0] CMD_WRITE = 3'd0;
    localparam logic [2:0] CMD_RUN   = 3'd1;
    localparam logic [2:0] CMD_READ  = 3'd2;
    localparam logic [2:0] CMD_LAYER = 3'd3;
    localparam logic [2:0] CMD_SCALE = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE, S_WR, S_RD_WAIT, S_RSP, S_RUN, S_FIN
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        w_accept;
    logic [31:0] w_addr_ext;
    logic        w_wr_ok;
    logic [1:0]  w_wr_sel;
    logic [23:0] w_wr_off;
    logic [2:0]  r_rd_cnt;
    logic        r_rd_bad;

    // Ready is gated by rst so the host sees no ready while reset is held.
    assign cmd_ready  = (r_state == S_IDLE) && !rst;
    assign w_accept   = cmd_valid && cmd_ready;
    assign w_addr_ext = {8'd0, cmd_addr};

    // Map a host byte address onto its region and region offset.
    always_comb begin
        w_wr_ok  = 1'b1;
        w_wr_sel = 2'd0;
        w_wr_off = cmd_addr;
        if (w_addr_ext < L_WBUF_END) begin
            w_wr_sel = 2'd0;
        end else if (w_addr_ext < L_FMAP_BASE) begin
            w_wr_sel = 2'd1;
            w_wr_off = cmd_addr - L_BIAS_OFF;
        end else if (w_addr_ext < L_FMAP_END) begin
            w_wr_sel = 2'd2;
            w_wr_off = cmd_addr - L_FMAP_OFF;
        end else begin
            w_wr_ok  = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    case (cmd_type)
                        CMD_WRITE: w_next = S_WR;
                        CMD_READ:  w_next = S_RD_WAIT;
                        CMD_RUN:   w_next = S_RUN;
                        default:   w_next = S_IDLE;
                    endcase
                end
            end
            S_WR:      w_next = S_IDLE;
            S_RD_WAIT: if (r_rd_cnt == 3'd0) w_next = S_RSP;
            S_RSP:     w_next = S_IDLE;
            S_RUN:     if (run_done) w_next = S_FIN;
            S_FIN:     w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Registered outputs, status registers and the read-latency down-counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid     <= 1'b0;
            rsp_data      <= 8'd0;
            mem_we        <= 1'b0;
            mem_re        <= 1'b0;
            mem_sel       <= 2'd0;
            mem_addr      <= 24'd0;
            mem_wdata     <= 8'd0;
            run_start     <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            current_layer <= 5'd0;
            scale         <= 16'd0;
            ping_pong     <= 1'b0;
            bad_cmd       <= 1'b0;
            r_rd_cnt      <= 3'd0;
            r_rd_bad      <= 1'b0;
        end else begin
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
            run_start <= 1'b0;
            rsp_valid <= 1'b0;
            done      <= 1'b0;

            if (w_accept) begin
                case (cmd_type)
                    CMD_WRITE: begin
                        if (w_wr_ok) begin
                            mem_we    <= 1'b1;
                            mem_sel   <= w_wr_sel;
                            mem_addr  <= w_wr_off;
                            mem_wdata <= cmd_data;
                        end else begin
                            bad_cmd   <= 1'b1;
                        end
                    end
                    CMD_READ: begin
                        r_rd_cnt <= L_RD_LAT;
                        if (w_addr_ext < L_FMAP_SIZE) begin
                            mem_re   <= 1'b1;
                            mem_sel  <= 2'd3;
                            mem_addr <= cmd_addr;
                            r_rd_bad <= 1'b0;
                        end else begin
                            r_rd_bad <= 1'b1;
                            bad_cmd  <= 1'b1;
                        end
                    end
                    CMD_RUN: begin
                        run_start <= 1'b1;
                        busy      <= 1'b1;
                    end
                    CMD_LAYER: current_layer <= cmd_data[4:0];
                    CMD_SCALE: begin
                        if (cmd_addr == 24'd0)      scale[7:0]  <= cmd_data;
                        else if (cmd_addr == 24'd1) scale[15:8] <= cmd_data;
                        else                        bad_cmd     <= 1'b1;
                    end
                    default: bad_cmd <= 1'b1;
                endcase
            end

            // An out-of-range read still answers, with a zero byte.
            if (r_state == S_RD_WAIT) begin
                if (r_rd_cnt == 3'd0) begin
                    rsp_valid <= 1'b1;
                    rsp_data  <= r_rd_bad ? 8'd0 : mem_rdata;
                end else begin
                    r_rd_cnt  <= r_rd_cnt - 3'd1;
                end
            end

            if (r_state == S_RUN && run_done) begin
                busy      <= 1'b0;
                done      <= 1'b1;
                ping_pong <= ~ping_pong;
            end
        end
    end

endmodule

// File: tb/tb_dpu_cmd_responder.sv
// Randomized self-checking bench for dpu_cmd_responder with a behavioural
// reference model (address map arithmetic, fmap byte array, status shadows).
module tb_dpu_cmd_responder;

    localparam int RD_LAT    = 1;
    localparam int MAX_WBUF  = 147456;
    localparam int FMAP_BASE = 148480;
    localparam int MAX_FMAP  = 65536;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_type;
    logic [23:0] cmd_addr;
    logic [7:0]  cmd_data;
    logic        rsp_valid;
    logic [7:0]  rsp_data;
    logic        mem_we;
    logic        mem_re;
    logic [1:0]  mem_sel;
    logic [23:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        run_start;
    logic        run_done;
    logic        busy;
    logic        done;
    logic [4:0]  current_layer;
    logic [15:0] scale;
    logic        ping_pong;
    logic        bad_cmd;

    int n_cmp = 0;
    int n_bad = 0;

    logic        exp_bad;
    logic [15:0] exp_scale;
    logic [4:0]  exp_layer;
    logic        exp_pp;

    logic [7:0] fmem [0:65535];
    logic [7:0] rd_pipe [RD_LAT];

    dpu_cmd_responder #(.RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_type(cmd_type), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .mem_we(mem_we),
        .mem_re(mem_re), .mem_sel(mem_sel), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .run_start(run_start),
        .run_done(run_done), .busy(busy), .done(done),
        .current_layer(current_layer), .scale(scale), .ping_pong(ping_pong),
        .bad_cmd(bad_cmd)
    );

    always #5 clk = ~clk;

    // Memory model: data for a read strobe appears RD_LAT cycles later; otherwise noise.
    assign mem_rdata = rd_pipe[RD_LAT-1];
    always @(posedge clk) begin
        rd_pipe[0] <= mem_re ? fmem[mem_addr[15:0]] : 8'($urandom);
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst = 1'b1; cmd_valid = 1'b0; run_done = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_bad = 1'b0; exp_scale = 16'd0; exp_layer = 5'd0; exp_pp = 1'b0;
    endtask

    task automatic send(input logic [2:0] t, input logic [23:0] a, input logic [7:0] d);
        logic got;
        got = 1'b0;
        cmd_type = t; cmd_addr = a; cmd_data = d; cmd_valid = 1'b1;
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge clk);
            if (cmd_ready) got = 1'b1;
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        n_cmp++;
        if (!got) begin
            $display("FAIL accept_timeout: cmd_ready got 0 expected 1 (type %0d)", t);
            n_bad++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; cmd_valid = 1'b0; run_done = 1'b0;
        cmd_type = 3'd0; cmd_addr = 24'd0; cmd_data = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        n_cmp++;
        if (cmd_ready !== 1'b0) begin $display("FAIL reset_ready_in_rst: got %b expected 0", cmd_ready); n_bad++; end
        n_cmp++;
        if ({rsp_valid, rsp_data, mem_we, mem_re, mem_sel, mem_addr, mem_wdata, run_start, busy,
             done, current_layer, scale, ping_pong, bad_cmd} !== 71'd0) begin
            $display("FAIL reset_outputs: got nonzero outputs expected all 0"); n_bad++;
        end
        @(posedge clk); #1;
        rst = 1'b0;
        exp_bad = 1'b0; exp_scale = 16'd0; exp_layer = 5'd0; exp_pp = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (cmd_ready !== 1'b1) begin $display("FAIL reset_ready_after: got %b expected 1", cmd_ready); n_bad++; end
        @(posedge clk); #1;
    endtask

    task automatic test_write();
        logic [23:0] a;
        logic [7:0]  d;
        logic [1:0]  es;
        logic [23:0] eo;
        logic        ok;
        int fixed [9] = '{5, 147458, 149247, 0, 147455, 147456, 148479, 148480, 214015};
        int bad_a [2] = '{214016, 24'hFFFFFF};
        for (int i = 0; i < 31; i++) begin
            if (i < 9) begin
                a = 24'(fixed[i]);
            end else if (i < 29) begin
                a = 24'($urandom_range(0, FMAP_BASE + MAX_FMAP - 1));
            end else begin
                do_reset();
                a = 24'(bad_a[i-29]);
            end
            d = (i == 0) ? 8'hA7 : 8'($urandom);
            ok = 1'b1; es = 2'd0; eo = a;
            if (a < MAX_WBUF)                   begin es = 2'd0; eo = a; end
            else if (a < FMAP_BASE)             begin es = 2'd1; eo = 24'(a - MAX_WBUF); end
            else if (a < FMAP_BASE + MAX_FMAP)  begin es = 2'd2; eo = 24'(a - FMAP_BASE); end
            else                                begin ok = 1'b0; exp_bad = 1'b1; end
            send(3'd0, a, d);
            @(negedge clk);
            n_cmp++;
            if (mem_we !== ok) begin $display("FAIL wr_we a=%h: got %b expected %b", a, mem_we, ok); n_bad++; end
            if (ok) begin
                n_cmp++;
                if ({mem_sel, mem_addr, mem_wdata} !== {es, eo, d}) begin
                    $display("FAIL wr_fields a=%h: got sel=%0d addr=%h data=%h expected sel=%0d addr=%h data=%h",
                             a, mem_sel, mem_addr, mem_wdata, es, eo, d);
                    n_bad++;
                end
            end
            n_cmp++;
            if (bad_cmd !== exp_bad) begin $display("FAIL wr_bad a=%h: got %b expected %b", a, bad_cmd, exp_bad); n_bad++; end
            n_cmp++;
            if (cmd_ready !== 1'b0) begin $display("FAIL wr_ready_t1: got %b expected 0", cmd_ready); n_bad++; end
            @(posedge clk); #1;
            @(negedge clk);
            n_cmp++;
            if ({mem_we, cmd_ready} !== 2'b01) begin
                $display("FAIL wr_t2: got we=%b ready=%b expected we=0 ready=1", mem_we, cmd_ready); n_bad++;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_read();
        logic [23:0] a;
        logic [7:0]  ed;
        logic        ok;
        int bad_a [2] = '{70000, 65536};
        for (int i = 0; i < 14; i++) begin
            if (i == 0)       a = 24'd3;
            else if (i == 1)  a = 24'd65535;
            else if (i < 12)  a = 24'($urandom_range(0, MAX_FMAP - 1));
            else begin
                do_reset();
                a = 24'(bad_a[i-12]);
            end
            ok = (a < MAX_FMAP);
            ed = ok ? fmem[a[15:0]] : 8'h00;
            if (!ok) exp_bad = 1'b1;
            send(3'd2, a, 8'($urandom));
            @(negedge clk);
            n_cmp++;
            if (mem_re !== ok) begin $display("FAIL rd_re a=%h: got %b expected %b", a, mem_re, ok); n_bad++; end
            if (ok) begin
                n_cmp++;
                if ({mem_sel, mem_addr} !== {2'd3, a}) begin
                    $display("FAIL rd_fields: got sel=%0d addr=%h expected sel=3 addr=%h", mem_sel, mem_addr, a); n_bad++;
                end
            end
            n_cmp++;
            if (bad_cmd !== exp_bad) begin $display("FAIL rd_bad a=%h: got %b expected %b", a, bad_cmd, exp_bad); n_bad++; end
            for (int k = 2; k <= 3 + RD_LAT; k++) begin
                @(posedge clk); #1;
                @(negedge clk);
                n_cmp++;
                if ({mem_re, rsp_valid, cmd_ready} !== {1'b0, k == 2 + RD_LAT, k == 3 + RD_LAT}) begin
                    $display("FAIL rd_timing a=%h T+%0d: got re=%b rv=%b rdy=%b expected re=0 rv=%b rdy=%b",
                             a, k, mem_re, rsp_valid, cmd_ready, k == 2 + RD_LAT, k == 3 + RD_LAT);
                    n_bad++;
                end
                if (k >= 2 + RD_LAT) begin
                    n_cmp++;
                    if (rsp_data !== ed) begin $display("FAIL rd_data a=%h T+%0d: got %h expected %h", a, k, rsp_data, ed); n_bad++; end
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_regs();
        logic [23:0] a;
        logic [7:0]  d;
        for (int i = 0; i < 8; i++) begin
            if (i == 0)      begin a = 24'd0; d = 8'h8F; end
            else if (i == 1) begin a = 24'd1; d = 8'h02; end
            else             begin a = 24'($urandom_range(0, 1)); d = 8'($urandom); end
            if (a == 24'd0) exp_scale[7:0] = d; else exp_scale[15:8] = d;
            send(3'd5, a, d);
            @(negedge clk);
            n_cmp++;
            if (i == 1 && scale !== 16'h028F) begin $display("FAIL scale_plan: got %h expected 028f", scale); n_bad++; end
            else if (scale !== exp_scale) begin $display("FAIL scale: got %h expected %h", scale, exp_scale); n_bad++; end
            n_cmp++;
            if (cmd_ready !== 1'b1) begin $display("FAIL scale_ready: got %b expected 1", cmd_ready); n_bad++; end
            @(posedge clk); #1;
        end
        send(3'd3, 24'($urandom), 8'hE4);
        exp_layer = 5'd4;
        @(negedge clk);
        n_cmp++;
        if (current_layer !== 5'd4) begin $display("FAIL layer_e4: got %0d expected 4", current_layer); n_bad++; end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [7:0] prev;
        logic [7:0] d;
        prev = 8'd0;
        cmd_type = 3'd3; cmd_addr = 24'd0; cmd_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            d = 8'($urandom);
            cmd_data = d;
            @(negedge clk);
            n_cmp++;
            if (cmd_ready !== 1'b1) begin $display("FAIL b2b_ready i=%0d: got %b expected 1", i, cmd_ready); n_bad++; end
            if (i > 0) begin
                n_cmp++;
                if (current_layer !== prev[4:0]) begin $display("FAIL b2b_layer i=%0d: got %0d expected %0d", i, current_layer, prev[4:0]); n_bad++; end
            end
            prev = d;
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        exp_layer = prev[4:0];
        @(negedge clk);
        n_cmp++;
        if (current_layer !== exp_layer) begin $display("FAIL b2b_last: got %0d expected %0d", current_layer, exp_layer); n_bad++; end
        @(posedge clk); #1;
    endtask

    task automatic test_run(input int delay);
        logic       got;
        logic       pp0;
        logic [7:0] ld;
        int         busy_n;
        int         done_n;
        pp0 = exp_pp; got = 1'b0; busy_n = 0; done_n = 0;
        ld = 8'($urandom);
        cmd_type = 3'd1; cmd_addr = 24'd0; cmd_data = 8'd0; cmd_valid = 1'b1;
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge clk);
            if (cmd_ready) got = 1'b1;
            @(posedge clk); #1;
        end
        n_cmp++;
        if (!got) begin $display("FAIL run_accept: cmd_ready got 0 expected 1"); n_bad++; end
        cmd_type = 3'd3; cmd_data = ld;
        for (int c = 1; c <= delay + 3; c++) begin
            run_done = (c == delay);
            if (c == delay + 3) cmd_valid = 1'b0;
            @(negedge clk);
            if (busy === 1'b1) busy_n++;
            if (done === 1'b1) done_n++;
            n_cmp++;
            if ({run_start, busy, done, cmd_ready} !== {c == 1, c <= delay, c == delay + 1, c >= delay + 2}) begin
                $display("FAIL run_cycle d=%0d c=%0d: got st=%b busy=%b done=%b rdy=%b expected st=%b busy=%b done=%b rdy=%b",
                         delay, c, run_start, busy, done, cmd_ready, c == 1, c <= delay, c == delay + 1, c >= delay + 2);
                n_bad++;
            end
            n_cmp++;
            if (ping_pong !== ((c >= delay + 1) ? ~pp0 : pp0)) begin
                $display("FAIL run_pp d=%0d c=%0d: got %b expected %b", delay, c, ping_pong, (c >= delay + 1) ? ~pp0 : pp0); n_bad++;
            end
            n_cmp++;
            if (current_layer !== ((c == delay + 3) ? ld[4:0] : exp_layer)) begin
                $display("FAIL run_hold_cmd d=%0d c=%0d: got layer %0d expected %0d", delay, c, current_layer,
                         (c == delay + 3) ? ld[4:0] : exp_layer);
                n_bad++;
            end
            @(posedge clk); #1;
        end
        run_done = 1'b0;
        exp_pp = ~pp0; exp_layer = ld[4:0];
        n_cmp++;
        if (busy_n != delay) begin $display("FAIL run_busy_len: got %0d expected %0d", busy_n, delay); n_bad++; end
        n_cmp++;
        if (done_n != 1) begin $display("FAIL run_done_count: got %0d expected 1", done_n); n_bad++; end
    endtask

    task automatic test_stray_done();
        run_done = 1'b1;
        @(posedge clk); #1;
        run_done = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({busy, done, ping_pong, cmd_ready} !== {2'b00, exp_pp, 1'b1}) begin
                $display("FAIL stray_done: got busy=%b done=%b pp=%b rdy=%b expected 0 0 %b 1", busy, done, ping_pong, cmd_ready, exp_pp);
                n_bad++;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_illegal();
        logic [2:0] ills [3] = '{3'd4, 3'd6, 3'd7};
        for (int i = 0; i < 3; i++) begin
            do_reset();
            send(ills[i], 24'($urandom), 8'($urandom));
            @(negedge clk);
            n_cmp++;
            if ({bad_cmd, mem_we, mem_re, busy, cmd_ready} !== 5'b10001) begin
                $display("FAIL illegal_type %0d: got bad=%b we=%b re=%b busy=%b rdy=%b expected 1 0 0 0 1",
                         ills[i], bad_cmd, mem_we, mem_re, busy, cmd_ready);
                n_bad++;
            end
            @(posedge clk); #1;
        end
        do_reset();
        send(3'd5, 24'd2, 8'hAA);
        @(negedge clk);
        n_cmp++;
        if ({bad_cmd, scale} !== {1'b1, 16'h0000}) begin
            $display("FAIL scale_bad_addr: got bad=%b scale=%h expected bad=1 scale=0000", bad_cmd, scale); n_bad++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_run();
        do_reset();
        send(3'd1, 24'd0, 8'd0);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_bad = 1'b0; exp_scale = 16'd0; exp_layer = 5'd0; exp_pp = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({busy, done, ping_pong, run_start, cmd_ready} !== 5'b00001) begin
            $display("FAIL rst_mid_run: got busy=%b done=%b pp=%b st=%b rdy=%b expected 0 0 0 0 1",
                     busy, done, ping_pong, run_start, cmd_ready);
            n_bad++;
        end
        @(posedge clk); #1;
        run_done = 1'b1;
        @(posedge clk); #1;
        run_done = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({busy, done, ping_pong} !== 3'b000) begin
                $display("FAIL late_run_done: got busy=%b done=%b pp=%b expected 0 0 0", busy, done, ping_pong); n_bad++;
            end
            @(posedge clk); #1;
        end
        send(3'd2, 24'd3, 8'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({rsp_valid, rsp_data} !== 9'd0) begin
                $display("FAIL rst_discard_rsp: got rv=%b data=%h expected rv=0 data=00", rsp_valid, rsp_data); n_bad++;
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) fmem[i] = 8'($urandom);
        fmem[3] = 8'h5C;
        test_reset();
        test_write();
        test_read();
        test_regs();
        test_back_to_back();
        test_run(51);
        test_run(1);
        test_run(int'($urandom_range(2, 30)));
        test_stray_done();
        test_illegal();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
